// File: rtl/mod_s2p.sv
// mod_s2p: transmit-side serial-to-symbol mapper for a 16QAM link.
//
// Serial bits are grouped LSB-first into nibbles. Each nibble is added
// (mod 16) into a running accumulator, and each accumulator half is
// Gray-mapped to a 2-bit level code. After start, a programmable number of
// reference symbols (accumulator = 0) is sent before data is accepted.
//
// Ports
//   clk_signal  in   bit-rate clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a burst (sampled in IDLE)
//   stop        in   end a burst (sampled in DATA)
//   signal      in   serial data bit
//   in_valid    in   signal carries a valid bit
//   in_ready    out  a bit is accepted this cycle (DATA only)
//   sym_i       out  I-axis Gray level code (registered)
//   sym_q       out  Q-axis Gray level code (registered)
//   sym_valid   out  one-cycle strobe: new symbol on sym_i/sym_q
//   busy        out  high in PREAMBLE or DATA
module mod_s2p #(
  parameter int unsigned PREAMBLE_SYMS = 2
) (
  input  logic       clk_signal,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       signal,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sym_i,
  output logic [1:0] sym_q,
  output logic       sym_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA
  } state_t;

  localparam logic [7:0] PRE_N = 8'(PREAMBLE_SYMS);

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [1:0] bitcnt_q, bitcnt_d;
  logic [7:0] precnt_q, precnt_d;
  // Only the three low nibble bits need storage; bit 3 is taken live.
  logic [2:0] nib_q, nib_d;
  logic [1:0] sym_i_q, sym_i_d;
  logic [1:0] sym_q_q, sym_q_d;
  logic       sym_valid_q, sym_valid_d;
  logic [3:0] acc_sum;

  function automatic logic [1:0] gray2(input logic [1:0] b);
    return {b[1], b[1] ^ b[0]};
  endfunction

  assign acc_sum = acc_q + {signal, nib_q};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bitcnt_d    = bitcnt_q;
    precnt_d    = precnt_q;
    nib_d       = nib_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    sym_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          bitcnt_d = '0;
          precnt_d = '0;
          nib_d    = '0;
          state_d  = (PRE_N == 8'd0) ? S_DATA : S_PRE;
        end
      end

      S_PRE: begin
        bitcnt_d = bitcnt_q + 2'd1;
        // Emitting on the edge that makes bitcnt 3 keeps sym_valid high
        // during the bitcnt==3 cycle, i.e. one pulse per 4-cycle slot.
        if (bitcnt_q == 2'd2) begin
          sym_i_d     = 2'b00;
          sym_q_d     = 2'b00;
          sym_valid_d = 1'b1;
          precnt_d    = precnt_q + 8'd1;
          if (precnt_q + 8'd1 == PRE_N) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
      end

      S_DATA: begin
        if (in_valid) begin
          bitcnt_d = bitcnt_q + 2'd1;
          if (bitcnt_q == 2'd3) begin
            acc_d       = acc_sum;
            sym_i_d     = gray2(acc_sum[3:2]);
            sym_q_d     = gray2(acc_sum[1:0]);
            sym_valid_d = 1'b1;
            nib_d       = '0;
          end else begin
            nib_d[bitcnt_q] = signal;
          end
        end
        // A completed nibble in the stop cycle is still emitted above;
        // any partial nibble is dropped here.
        if (stop) begin
          state_d  = S_IDLE;
          bitcnt_d = '0;
          nib_d    = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_signal or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      bitcnt_q    <= '0;
      precnt_q    <= '0;
      nib_q       <= '0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bitcnt_q    <= bitcnt_d;
      precnt_q    <= precnt_d;
      nib_q       <= nib_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign in_ready  = (state_q == S_DATA);
  assign busy      = (state_q != S_IDLE);
  assign sym_i     = sym_i_q;
  assign sym_q     = sym_q_q;
  assign sym_valid = sym_valid_q;

endmodule

// File: tb/tb_mod_s2p.sv
module tb_mod_s2p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance 0: PREAMBLE_SYMS = 2
  logic       start0 = 0, stop0 = 0, sig0 = 0, iv0 = 0;
  logic       rdy0, sv0, busy0;
  logic [1:0] si0, sq0;
  // Instance 1: PREAMBLE_SYMS = 0
  logic       start1 = 0, stop1 = 0, sig1 = 0, iv1 = 0;
  logic       rdy1, sv1, busy1;
  logic [1:0] si1, sq1;

  int errors = 0;
  int checks = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  mod_s2p #(.PREAMBLE_SYMS(2)) u0 (
    .clk_signal(clk), .rst_n(rst_n), .start(start0), .stop(stop0),
    .signal(sig0), .in_valid(iv0), .in_ready(rdy0), .sym_i(si0),
    .sym_q(sq0), .sym_valid(sv0), .busy(busy0)
  );

  mod_s2p #(.PREAMBLE_SYMS(0)) u1 (
    .clk_signal(clk), .rst_n(rst_n), .start(start1), .stop(stop1),
    .signal(sig1), .in_valid(iv1), .in_ready(rdy1), .sym_i(si1),
    .sym_q(sq1), .sym_valid(sv1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop one expected {I,Q} per sym_valid pulse.
  always @(negedge clk) begin
    if (sv0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_sym: got %b%b, expected no symbol", si0, sq0);
      end else begin
        chk("u0_sym", {28'd0, si0, sq0}, {28'd0, q0.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (sv1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_sym: got %b%b, expected no symbol", si1, sq1);
      end else begin
        chk("u1_sym", {28'd0, si1, sq1}, {28'd0, q1.pop_front()});
      end
    end
  end

  // Drive one bit for one cycle; caller is at a negedge, returns at the next.
  task automatic send_bit0(input logic b);
    sig0 = b; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic send_bit1(input logic b);
    sig1 = b; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
  endtask

  // Full nibble LSB-first; the expected symbol is queued as the 4th bit is driven.
  task automatic send_nib0(input logic [3:0] n, input logic [3:0] exp_iq);
    logic [3:0] nn;
    nn = n;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) q0.push_back(exp_iq);
      send_bit0(nn[b]);
    end
    chk("u0_sv_on_4th_bit", {31'd0, sv0}, 32'd1);
  endtask

  task automatic send_nib1(input logic [3:0] n, input logic [3:0] exp_iq);
    logic [3:0] nn;
    nn = n;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) q1.push_back(exp_iq);
      send_bit1(nn[b]);
    end
    chk("u1_sv_on_4th_bit", {31'd0, sv1}, 32'd1);
  endtask

  // Start a burst on u0 and check the preamble timing cycle by cycle.
  // Cycle k is the one after edge E0+k-1; pulses expected at k=4 and k=8,
  // with in_ready rising together with the second pulse.
  task automatic start_burst0();
    start0 = 1'b1;
    q0.push_back(4'b0000);
    q0.push_back(4'b0000);
    @(negedge clk);
    start0 = 1'b0;
    chk("pre_busy", {31'd0, busy0}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("pre_sv_k%0d", k), {31'd0, sv0}, (k == 4 || k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("pre_rdy_k%0d", k), {31'd0, rdy0}, (k >= 8) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, rdy0}, 0);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_sv", {31'd0, sv0}, 0);
    chk("rst_sym", {28'd0, si0, sq0}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rdy", {31'd0, rdy0}, 0);

    // Burst 1: preamble, then nibbles 0x1, 0x3, 0xF back to back -> acc 1, 4, 3
    start_burst0();
    send_nib0(4'h1, 4'b00_01);
    send_nib0(4'h3, 4'b01_00);
    send_nib0(4'hF, 4'b00_10);
    @(negedge clk);
    chk("hold_sym", {28'd0, si0, sq0}, {28'd0, 4'b00_10});
    chk("hold_sv", {31'd0, sv0}, 0);

    // Stall: nibble 0x6 (bits 0,1,1,0), 5-cycle gap after 2 bits -> acc 9
    send_bit0(1'b0);
    send_bit0(1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_sv", {31'd0, sv0}, 0);
      chk("stall_rdy", {31'd0, rdy0}, 1);
    end
    send_bit0(1'b1);
    q0.push_back(4'b11_01);
    send_bit0(1'b0);
    chk("stall_resume_sv", {31'd0, sv0}, 1);

    // Stop after 3 bits: no symbol, IDLE next cycle
    send_bit0(1'b1);
    send_bit0(1'b1);
    send_bit0(1'b1);
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    chk("stop3_rdy", {31'd0, rdy0}, 0);
    chk("stop3_busy", {31'd0, busy0}, 0);
    chk("stop3_sv", {31'd0, sv0}, 0);
    repeat (3) @(negedge clk);
    chk("idle_hold_sym", {28'd0, si0, sq0}, {28'd0, 4'b11_01});

    // Burst 2: acc cleared by start; 0xE -> acc E, then 0x5 with stop on 4th bit -> acc 3
    start_burst0();
    send_nib0(4'hE, 4'b10_11);
    send_bit0(1'b1);
    send_bit0(1'b0);
    send_bit0(1'b1);
    sig0 = 1'b0; iv0 = 1'b1; stop0 = 1'b1;
    q0.push_back(4'b00_10);
    @(negedge clk);
    iv0 = 1'b0; stop0 = 1'b0;
    chk("stop4_sv", {31'd0, sv0}, 1);
    chk("stop4_rdy", {31'd0, rdy0}, 0);
    chk("stop4_busy", {31'd0, busy0}, 0);
    @(negedge clk);
    chk("stop4_sv_after", {31'd0, sv0}, 0);

    // Instance with no preamble: in_ready next cycle, acc restarts each burst
    for (int r = 0; r < 2; r++) begin
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("np_rdy", {31'd0, rdy1}, 1);
      chk("np_busy", {31'd0, busy1}, 1);
      send_nib1(4'h2, 4'b00_11);
      stop1 = 1'b1;
      @(negedge clk);
      stop1 = 1'b0;
      chk("np_stop_rdy", {31'd0, rdy1}, 0);
    end

    // Burst 3: reset mid-DATA with bitcnt = 2
    start_burst0();
    send_nib0(4'hE, 4'b10_11);
    send_bit0(1'b0);
    send_bit0(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, rdy0}, 0);
    chk("mid_rst_busy", {31'd0, busy0}, 0);
    chk("mid_rst_sv", {31'd0, sv0}, 0);
    chk("mid_rst_sym", {28'd0, si0, sq0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_rdy", {31'd0, rdy0}, 0);
      chk("post_rst_busy", {31'd0, busy0}, 0);
    end

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
